ov7670_emulador_tx: RTL

- Synthesizable emulator of the OV7670 parallel video output: VSYNC, HREF, PCLK and D[7:0] in RGB565, two bytes per pixel, high byte first.
- Loops back into the capture interface on the FPGA, so capture, quadrant counting and storage can be brought up and regression-tested without a camera.
- Sits beside the capture path. Its outputs drive the capture inputs directly, or through GPIO jumpers.

---
 rtl/ov7670_pkg.sv | 32 +++
 rtl/ov7670_pclk_gen.sv | 36 +++
 rtl/ov7670_emulador_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 output emulator: state codes, pattern
// encodings and the 3x3 grid colour table.
`default_nettype none

package ov7670_pkg;

  typedef enum logic [3:0] {
    ST_OCIOSO  = 4'd0,
    ST_VSYNC   = 4'd1,
    ST_BACK    = 4'd2,
    ST_ATIVA   = 4'd3,
    ST_BLANK_H = 4'd4,
    ST_FIM     = 4'd5
  } estado_t;

  localparam logic [1:0] PADRAO_CONST    = 2'd0;
  localparam logic [1:0] PADRAO_CONTADOR = 2'd1;
  localparam logic [1:0] PADRAO_GRADE    = 2'd2;
  localparam logic [1:0] PADRAO_RESERV   = 2'd3;

  localparam int BYTES_POR_PIXEL = 2;

  // RGB565: white, yellow, red, orange, blue, green, grey, magenta, cyan
  localparam logic [15:0] CORES_GRADE [0:8] = '{
    16'hFFFF, 16'hFFE0, 16'hF800,
    16'hFD20, 16'h001F, 16'h07E0,
    16'h7BEF, 16'hF81F, 16'h07FF
  };

endpackage

`default_nettype wire

// File: rtl/ov7670_pclk_gen.sv
// Free-running PCLK divider; tick_o marks the clock on which PCLK falls.
`default_nettype none

module ov7670_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic pclk_o,
  output logic tick_o
);

  localparam int CW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(PCLK_DIV - 1);

  logic [CW-1:0] div_q;
  logic          pclk_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      pclk_q <= ~pclk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign pclk_o = pclk_q;
  assign tick_o = pclk_q && (div_q == DIV_LAST);

endmodule

`default_nettype wire

// File: rtl/ov7670_emulador_tx.sv
// OV7670 parallel video emulator: VSYNC/HREF/PCLK/D in RGB565, high byte first.
// All frame outputs move only on PCLK falling ticks so the receiver samples stable data.
`default_nettype none

module ov7670_emulador_tx
  import ov7670_pkg::*;
#(
  parameter int LINES       = 140,
  parameter int COLUMNS     = 320,
  parameter int S_LINE      = 8,
  parameter int S_COLUMN    = 9,
  parameter int PCLK_DIV    = 2,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        iniciar_i,
  input  logic        continuo_i,
  input  logic [1:0]  padrao_i,
  input  logic [15:0] cor_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic        pclk_o,
  output logic [7:0]  d_o,
  output logic        ocupado_o,
  output logic        fim_frame_o,
  output logic [3:0]  db_estado_o
);

  localparam int LINE_TIME   = 2 * COLUMNS + H_BLANK;
  localparam int VS_TICKS    = VSYNC_LINES * LINE_TIME;
  localparam int BK_TICKS    = V_BACK * LINE_TIME;
  localparam int ATIVA_TICKS = BYTES_POR_PIXEL * COLUMNS;
  localparam int CNT_W       = $clog2(VS_TICKS + BK_TICKS + ATIVA_TICKS + H_BLANK + 1);
  localparam int QC_LEN      = (COLUMNS / 3 > 0) ? COLUMNS / 3 : 1;
  localparam int QL_LEN      = (LINES / 3 > 0) ? LINES / 3 : 1;

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    VS_END   = CNT_W'(VS_TICKS);
  localparam logic [CNT_W-1:0]    BK_END   = CNT_W'(BK_TICKS);
  localparam logic [CNT_W-1:0]    AT_END   = CNT_W'(ATIVA_TICKS);
  localparam logic [CNT_W-1:0]    HB_END   = CNT_W'(H_BLANK);
  localparam logic [S_COLUMN-1:0] COL_LAST = S_COLUMN'(COLUMNS - 1);
  localparam logic [S_LINE-1:0]   LIN_LAST = S_LINE'(LINES - 1);
  localparam logic [S_COLUMN-1:0] QC_LAST  = S_COLUMN'(QC_LEN - 1);
  localparam logic [S_LINE-1:0]   QL_LAST  = S_LINE'(QL_LEN - 1);

  logic tick;

  ov7670_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .pclk_o  (pclk_o),
    .tick_o  (tick)
  );

  estado_t              state_q;
  logic                 pend_q;
  logic                 vsync_q;
  logic                 href_q;
  logic [7:0]           d_q;
  logic                 fim_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           padrao_q;
  logic [15:0]          cor_q;
  logic [15:0]          pix_idx_q;
  logic [S_COLUMN-1:0]  col_q, col_d, subc_q, subc_d;
  logic [S_LINE-1:0]    lin_q, lin_d, subl_q, subl_d;
  logic [1:0]           qcol_q, qcol_d, qlin_q, qlin_d;
  logic [3:0]           grade_idx;
  logic [15:0]          pixel;
  logic                 inicia_frame;

  // Position advance after a pixel's low byte; quadrant indices saturate at 2
  // so leftover columns/lines fall into the last quadrant.
  always_comb begin
    col_d  = col_q + 1'b1;
    subc_d = subc_q + 1'b1;
    qcol_d = qcol_q;
    lin_d  = lin_q;
    subl_d = subl_q;
    qlin_d = qlin_q;
    if (subc_q == QC_LAST) begin
      subc_d = '0;
      if (qcol_q != 2'd2) qcol_d = qcol_q + 2'd1;
    end
    if (col_q == COL_LAST) begin
      col_d  = '0;
      subc_d = '0;
      qcol_d = '0;
      lin_d  = lin_q + 1'b1;
      subl_d = subl_q + 1'b1;
      if (subl_q == QL_LAST) begin
        subl_d = '0;
        if (qlin_q != 2'd2) qlin_d = qlin_q + 2'd1;
      end
      if (lin_q == LIN_LAST) begin
        lin_d  = '0;
        subl_d = '0;
        qlin_d = '0;
      end
    end
  end

  always_comb begin
    grade_idx = {2'b00, qlin_q} * 4'd3 + {2'b00, qcol_q};
    case (padrao_q)
      PADRAO_CONST:    pixel = cor_q;
      PADRAO_CONTADOR: pixel = pix_idx_q;
      PADRAO_GRADE:    pixel = CORES_GRADE[grade_idx];
      default:         pixel = 16'h0000;
    endcase
  end

  assign inicia_frame = tick && (((state_q == ST_OCIOSO) && pend_q) ||
                                 ((state_q == ST_FIM) && continuo_i));

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= ST_OCIOSO;
      pend_q    <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      d_q       <= 8'h00;
      fim_q     <= 1'b0;
      cnt_q     <= '0;
      padrao_q  <= PADRAO_CONST;
      cor_q     <= 16'h0000;
      pix_idx_q <= 16'h0000;
      col_q     <= '0;
      subc_q    <= '0;
      qcol_q    <= '0;
      lin_q     <= '0;
      subl_q    <= '0;
      qlin_q    <= '0;
    end else begin
      fim_q <= 1'b0;
      if (state_q != ST_OCIOSO || (tick && pend_q)) pend_q <= 1'b0;
      else pend_q <= pend_q | iniciar_i;

      if (inicia_frame) begin
        state_q   <= ST_VSYNC;
        vsync_q   <= 1'b1;
        href_q    <= 1'b0;
        d_q       <= 8'h00;
        cnt_q     <= CNT_ONE;
        padrao_q  <= padrao_i;
        cor_q     <= cor_i;
        pix_idx_q <= 16'h0000;
        col_q     <= '0;
        subc_q    <= '0;
        qcol_q    <= '0;
        lin_q     <= '0;
        subl_q    <= '0;
        qlin_q    <= '0;
      end else if (tick) begin
        case (state_q)
          ST_OCIOSO: ;
          ST_VSYNC: begin
            if (cnt_q == VS_END) begin
              state_q <= ST_BACK;
              vsync_q <= 1'b0;
              cnt_q   <= CNT_ONE;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_BACK: begin
            if (cnt_q == BK_END) begin
              state_q <= ST_ATIVA;
              href_q  <= 1'b1;
              d_q     <= pixel[15:8];
              cnt_q   <= CNT_ONE;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_ATIVA: begin
            if (cnt_q == AT_END) begin
              state_q <= ST_BLANK_H;
              href_q  <= 1'b0;
              d_q     <= 8'h00;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              // odd count: high byte already out, send low byte and move on
              if (cnt_q[0]) begin
                d_q       <= pixel[7:0];
                pix_idx_q <= pix_idx_q + 16'd1;
                col_q     <= col_d;
                subc_q    <= subc_d;
                qcol_q    <= qcol_d;
                lin_q     <= lin_d;
                subl_q    <= subl_d;
                qlin_q    <= qlin_d;
              end else begin
                d_q <= pixel[15:8];
              end
            end
          end
          ST_BLANK_H: begin
            if (cnt_q == HB_END) begin
              cnt_q <= CNT_ONE;
              // line counter wrapped during the last pixel of the frame
              if (lin_q == '0) begin
                state_q <= ST_FIM;
                fim_q   <= 1'b1;
              end else begin
                state_q <= ST_ATIVA;
                href_q  <= 1'b1;
                d_q     <= pixel[15:8];
              end
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_FIM:  state_q <= ST_OCIOSO;
          default: state_q <= ST_OCIOSO;
        endcase
      end
    end
  end

  assign vsync_o     = vsync_q;
  assign href_o      = href_q;
  assign d_o         = d_q;
  assign fim_frame_o = fim_q;
  assign ocupado_o   = (state_q != ST_OCIOSO);
  assign db_estado_o = state_q;

endmodule

`default_nettype wire
